psr_flag_stack: RTL and testbench
=================================

PSR_FLAG_STACK -- requirements
Module: psr_flag_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bit width of the bus value that flags are derived from (minimum 2).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of flag-save stack entries (minimum 1).
REQ-003 SHALL have parameter EXT_FLAGS, default 0, meaning 1 enables the C and V flags, 0 ties them to 0.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port LD_CC  input  1  load flags from bus_in, carry_in and ovf_in.
REQ-007 SHALL have port LD_BEN  input  1  load BEN from the current flags and cond_in.
REQ-008 SHALL have port Push  input  1  save the current flag vector on the stack (interrupt entry).
REQ-009 SHALL have port Pop  input  1  restore the flag vector from the stack (return from interrupt).
REQ-010 SHALL have port bus_in  input  WIDTH  value that N/Z/P are derived from.
REQ-011 SHALL have port carry_in  input  1  ALU carry-out.
REQ-012 SHALL have port ovf_in  input  1  ALU signed overflow.
REQ-013 SHALL have port cond_in  input  5  branch mask: [4]=n, [3]=z, [2]=p, [1]=c, [0]=v.
REQ-014 SHALL have ports N, Z, P, C, V  output  1 each  registered flags.
REQ-015 SHALL have port BEN  output  1  registered branch-enable.
REQ-016 SHALL have port depth  output  $clog2(DEPTH+1)  number of occupied stack entries.
REQ-017 SHALL have ports full and empty  output  1 each  depth==DEPTH and depth==0 respectively.
REQ-018 SHALL have port err  output  1  one-cycle pulse flagging an illegal stack operation.

Function
REQ-019 LD_CC SHALL set N=bus_in[WIDTH-1], Z=(bus_in==0) and P=~N&~Z, and SHALL set C=carry_in and V=ovf_in when EXT_FLAGS=1; exactly one of N/Z/P is 1 after any LD_CC.
REQ-020 LD_BEN SHALL set BEN=(N&cond_in[4])|(Z&cond_in[3])|(P&cond_in[2])|(C&cond_in[1])|(V&cond_in[0]), using pre-edge flag values (1-cycle latency; concurrent LD_CC is not visible).
REQ-021 BEN SHALL hold its value when LD_BEN is 0.
REQ-022 A Push while not full SHALL write the pre-edge {N,Z,P,C,V} to entry[depth] and increment depth.
REQ-023 A Pop while not empty SHALL load flags from entry[depth-1] and decrement depth; the flags are visible the following cycle.
REQ-024 Push while full, or Pop while empty, SHALL leave the stack and flags unchanged and pulse err for 1 cycle.
REQ-025 Push and Pop asserted together SHALL be ignored and SHALL pulse err for 1 cycle; LD_CC in that cycle still applies.
REQ-026 Pop and LD_CC asserted together SHALL restore from the stack (Pop wins) when the Pop is legal; otherwise LD_CC applies.
REQ-027 Push and LD_CC asserted together SHALL save the pre-edge flags and load the new flags into N..V.
REQ-028 The stack SHALL be LIFO with no wrap-around; depth saturates at 0 and DEPTH.
REQ-029 err SHALL be 0 in every cycle that has no illegal operation.

Reset
REQ-030 Reset low SHALL immediately clear N, Z, P, C, V, BEN, err and depth to 0 (empty=1, full=0), regardless of Clk.
REQ-031 Stack entry contents need not be cleared, and SHALL be unobservable until re-pushed.
REQ-032 Reset asserted mid-operation SHALL abort any Push or Pop in that cycle, and the first edge after deassertion SHALL act normally.

Structure
REQ-033 A shared package SHALL define the flag-vector struct {N,Z,P,C,V}, the cond_in bit-index constants and the default WIDTH/DEPTH.
REQ-034 The stack storage and pointer SHALL be a single sub-module, flag_lifo, parametrised by DEPTH and the entry width.
REQ-035 The flag/BEN logic SHALL remain in psr_flag_stack.

Verification
REQ-036 Reset, then LD_CC with bus_in=16'h8000 -> N=1, Z=0, P=0; then bus_in=16'h0000 -> Z=1; then bus_in=16'h0001 -> P=1.
REQ-037 Flags Z=1, then LD_BEN with cond_in=5'b01000 -> BEN=1 next cycle; cond_in=5'b10100 -> BEN=0.
REQ-038 EXT_FLAGS=1, LD_CC with carry_in=1 and ovf_in=1, then cond_in=5'b00010 -> BEN=1; with EXT_FLAGS=0 the same stimulus -> C=V=0 and BEN=0.
REQ-039 DEPTH=4: push with P=1, then N=1, Z=1, N=1, then a fifth Push -> full=1 and err pulses; four Pops restore N, Z, N, P in order; a fifth Pop -> err pulses and empty=1.
REQ-040 Push+Pop in the same cycle -> depth unchanged and err=1; Pop+LD_CC (bus_in=0) with depth=1 -> restored flags win and depth=0.
REQ-041 Reset pulsed low between clock edges with depth=3 -> depth=0 and all flags=0 before the next edge.

Source files
------------

// File: rtl/psr_flag_stack_pkg.sv
// Shared definitions for the processor-status flag block: flag vector layout,
// branch-mask bit positions and default sizing.
package psr_flag_stack_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 4;
  localparam int FLAG_W        = 5;

  // Bit positions inside cond_in; they line up with the flag vector order.
  localparam int COND_N = 4;
  localparam int COND_Z = 3;
  localparam int COND_P = 2;
  localparam int COND_C = 1;
  localparam int COND_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
    logic c;
    logic v;
  } flags_t;

  // Branch-enable: any flag that is set and selected by the mask.
  function automatic logic branch_enable(flags_t f, logic [FLAG_W-1:0] cond);
    return (f.n & cond[COND_N]) | (f.z & cond[COND_Z]) | (f.p & cond[COND_P]) |
           (f.c & cond[COND_C]) | (f.v & cond[COND_V]);
  endfunction

endpackage

// File: rtl/psr_flag_stack_flag_lifo.sv
// Flag-save LIFO: storage array plus occupancy pointer. The top entry is read
// combinationally so a legal pop can restore flags on the same edge that
// decrements the pointer. Illegal requests are rejected and reported by err.
module flag_lifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 5,
  localparam int DW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               pop_ack,
  output logic [DW-1:0]      depth,
  output logic               full,
  output logic               empty,
  output logic               err
);

  logic [DW-1:0]      depth_reg, depth_next;
  logic [DW-1:0]      depth_m1;
  logic               err_reg, err_next;
  logic               push_ok, pop_ok;
  logic [AW-1:0]      wr_idx, rd_idx;
  logic [ENTRY_W-1:0] mem [DEPTH];

  assign full     = (depth_reg == DW'(DEPTH));
  assign empty    = (depth_reg == '0);
  assign depth_m1 = depth_reg - DW'(1);
  assign wr_idx   = depth_reg[AW-1:0];
  assign rd_idx   = depth_m1[AW-1:0];

  // Decide legality of the request and the next occupancy; simultaneous
  // push and pop is rejected outright.
  always_comb begin
    push_ok    = push & ~pop & ~full;
    pop_ok     = pop & ~push & ~empty;
    err_next   = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);
    depth_next = depth_reg;
    if (push_ok) begin
      depth_next = depth_reg + DW'(1);
    end else if (pop_ok) begin
      depth_next = depth_m1;
    end
  end

  // Occupancy and error pulse; cleared immediately by reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      depth_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      depth_reg <= depth_next;
      err_reg   <= err_next;
    end
  end

  // Entry storage is never cleared: a write during reset lands above the
  // (zero) pointer and is overwritten before it can be popped.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Capture the pre-edge flags into the slot the pointer addresses.
    always_ff @(posedge Clk) begin
      if (push_ok && (wr_idx == AW'(gi))) begin
        mem[gi] <= wr_data;
      end
    end
  end

  assign rd_data = mem[rd_idx];
  assign pop_ack = pop_ok;
  assign depth   = depth_reg;
  assign err     = err_reg;

endmodule

// File: rtl/psr_flag_stack.sv
// Processor status flags N/Z/P (plus optional C/V), branch-enable register and
// an interrupt flag-save stack. A legal pop takes priority over LD_CC.
module psr_flag_stack
  import psr_flag_stack_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int EXT_FLAGS = 0,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  input  logic             Push,
  input  logic             Pop,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             carry_in,
  input  logic             ovf_in,
  input  logic [4:0]       cond_in,
  output logic             N,
  output logic             Z,
  output logic             P,
  output logic             C,
  output logic             V,
  output logic             BEN,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             err
);

  flags_t              flags_reg, flags_next;
  flags_t              cc_flags, rd_flags;
  logic                ben_reg, ben_next;
  logic                pop_ack;
  logic [FLAG_W-1:0]   wr_raw, rd_raw;

  assign wr_raw   = flags_reg;
  assign rd_flags = flags_t'(rd_raw);

  flag_lifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (FLAG_W)
  ) u_lifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .push    (Push),
    .pop     (Pop),
    .wr_data (wr_raw),
    .rd_data (rd_raw),
    .pop_ack (pop_ack),
    .depth   (depth),
    .full    (full),
    .empty   (empty),
    .err     (err)
  );

  // Flags derived from the bus; C/V tied low unless extended flags enabled.
  always_comb begin
    cc_flags   = '0;
    cc_flags.n = bus_in[WIDTH-1];
    cc_flags.z = (bus_in == '0);
    cc_flags.p = ~cc_flags.n & ~cc_flags.z;
    cc_flags.c = (EXT_FLAGS != 0) ? carry_in : 1'b0;
    cc_flags.v = (EXT_FLAGS != 0) ? ovf_in : 1'b0;
  end

  // Next flags: legal restore wins over LD_CC; BEN samples pre-edge flags.
  always_comb begin
    flags_next = flags_reg;
    ben_next   = ben_reg;
    if (pop_ack) begin
      flags_next = rd_flags;
      if (EXT_FLAGS == 0) begin
        flags_next.c = 1'b0;
        flags_next.v = 1'b0;
      end
    end else if (LD_CC) begin
      flags_next = cc_flags;
    end
    if (LD_BEN) begin
      ben_next = branch_enable(flags_reg, cond_in);
    end
  end

  // Flag and BEN registers with immediate reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      flags_reg <= '0;
      ben_reg   <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      ben_reg   <= ben_next;
    end
  end

  assign N   = flags_reg.n;
  assign Z   = flags_reg.z;
  assign P   = flags_reg.p;
  assign C   = flags_reg.c;
  assign V   = flags_reg.v;
  assign BEN = ben_reg;

endmodule

// File: tb/tb_psr_flag_stack.sv
// Directed bench: two instances (C/V disabled and enabled) share stimulus.
// Expected post-edge state is queued at drive time and compared by a monitor.
module tb_psr_flag_stack;

  logic        Clk;
  logic        Reset;
  logic        LD_CC, LD_BEN, Push, Pop;
  logic [15:0] bus_in;
  logic        carry_in, ovf_in;
  logic [4:0]  cond_in;

  logic        N0, Z0, P0, C0, V0, BEN0, full0, empty0, err0;
  logic [2:0]  depth0;
  logic        N1, Z1, P1, C1, V1, BEN1, full1, empty1, err1;
  logic [2:0]  depth1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [11:0] e0;
    logic [11:0] e1;
  } exp_t;

  exp_t sb[$];

  localparam logic [4:0] FN = 5'b10000;
  localparam logic [4:0] FZ = 5'b01000;
  localparam logic [4:0] FP = 5'b00100;

  psr_flag_stack #(.WIDTH(16), .DEPTH(4), .EXT_FLAGS(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .Push(Push), .Pop(Pop),
    .bus_in(bus_in), .carry_in(carry_in), .ovf_in(ovf_in), .cond_in(cond_in),
    .N(N0), .Z(Z0), .P(P0), .C(C0), .V(V0), .BEN(BEN0),
    .depth(depth0), .full(full0), .empty(empty0), .err(err0)
  );

  psr_flag_stack #(.WIDTH(16), .DEPTH(4), .EXT_FLAGS(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .LD_CC(LD_CC), .LD_BEN(LD_BEN), .Push(Push), .Pop(Pop),
    .bus_in(bus_in), .carry_in(carry_in), .ovf_in(ovf_in), .cond_in(cond_in),
    .N(N1), .Z(Z1), .P(P1), .C(C1), .V(V1), .BEN(BEN1),
    .depth(depth1), .full(full1), .empty(empty1), .err(err1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Observed vector: {N,Z,P,C,V,BEN,depth[2:0],full,empty,err}
  function automatic logic [11:0] obs0();
    return {N0, Z0, P0, C0, V0, BEN0, depth0, full0, empty0, err0};
  endfunction

  function automatic logic [11:0] obs1();
    return {N1, Z1, P1, C1, V1, BEN1, depth1, full1, empty1, err1};
  endfunction

  function automatic logic [11:0] mk(logic [4:0] f, logic b, int d, logic e);
    logic [2:0] d3;
    d3 = d[2:0];
    return {f, b, d3, (d == 4), (d == 0), e};
  endfunction

  task automatic check(string name, logic [11:0] got, logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (NZPCV_BEN_depth_full_empty_err)", name, got, exp);
    end else begin
      $display("ok   %s state=%b", name, got);
    end
  endtask

  task automatic drive(bit ldcc, bit ldben, bit push, bit pop, logic [15:0] bus,
                       bit cin, bit oin, logic [4:0] cond);
    LD_CC = ldcc; LD_BEN = ldben; Push = push; Pop = pop;
    bus_in = bus; carry_in = cin; ovf_in = oin; cond_in = cond;
  endtask

  // One clock of stimulus; queues the state expected after the next edge.
  task automatic cyc(string name, bit ldcc, bit ldben, bit push, bit pop,
                     logic [15:0] bus, bit cin, bit oin, logic [4:0] cond,
                     logic [4:0] f0, logic [4:0] f1, logic b0, logic b1,
                     int d, logic e);
    exp_t it;
    @(negedge Clk);
    drive(ldcc, ldben, push, pop, bus, cin, oin, cond);
    it.name = name;
    it.e0   = mk(f0, b0, d, e);
    it.e1   = mk(f1, b1, d, e);
    sb.push_back(it);
  endtask

  // Monitor: state is presented every edge; compare against queued entries.
  initial begin
    exp_t it;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        check({it.name, "/ext0"}, obs0(), it.e0);
        check({it.name, "/ext1"}, obs1(), it.e1);
      end
    end
  end

  initial begin
    exp_t it;
    int   wait_cycles;
    Reset = 1'b0;
    drive(0, 0, 0, 0, 16'h0000, 0, 0, 5'b00000);
    repeat (2) @(posedge Clk);
    #1;
    check("reset/ext0", obs0(), mk(5'b0, 0, 0, 0));
    check("reset/ext1", obs1(), mk(5'b0, 0, 0, 0));
    @(negedge Clk);
    Reset = 1'b1;

    //   name              cc ben pu po bus       ci oi cond      f0 f1        b0 b1 d e
    cyc("ldcc_neg",        1, 0, 0, 0, 16'h8000, 0, 0, 5'b00000, FN, FN,       0, 0, 0, 0);
    cyc("ldcc_zero",       1, 0, 0, 0, 16'h0000, 0, 0, 5'b00000, FZ, FZ,       0, 0, 0, 0);
    cyc("ldcc_pos",        1, 0, 0, 0, 16'h0001, 0, 0, 5'b00000, FP, FP,       0, 0, 0, 0);
    cyc("ldcc_zero2",      1, 0, 0, 0, 16'h0000, 0, 0, 5'b00000, FZ, FZ,       0, 0, 0, 0);
    cyc("ben_z",           0, 1, 0, 0, 16'h0000, 0, 0, 5'b01000, FZ, FZ,       1, 1, 0, 0);
    cyc("ben_hold",        0, 0, 0, 0, 16'h0000, 0, 0, 5'b10100, FZ, FZ,       1, 1, 0, 0);
    cyc("ben_np",          0, 1, 0, 0, 16'h0000, 0, 0, 5'b10100, FZ, FZ,       0, 0, 0, 0);
    cyc("ben_preedge",     1, 1, 0, 0, 16'h8000, 0, 0, 5'b01000, FN, FN,       1, 1, 0, 0);
    cyc("ldcc_cv",         1, 0, 0, 0, 16'h0001, 1, 1, 5'b00000, FP, 5'b00111, 1, 1, 0, 0);
    cyc("ben_c",           0, 1, 0, 0, 16'h0000, 0, 0, 5'b00010, FP, 5'b00111, 0, 1, 0, 0);
    cyc("ldcc_clr",        1, 0, 0, 0, 16'h0001, 0, 0, 5'b00000, FP, FP,       0, 1, 0, 0);
    cyc("push1",           0, 0, 1, 0, 16'h0000, 0, 0, 5'b00000, FP, FP,       0, 1, 1, 0);
    cyc("ldcc_n",          1, 0, 0, 0, 16'h8000, 0, 0, 5'b00000, FN, FN,       0, 1, 1, 0);
    cyc("push2_ldcc",      1, 0, 1, 0, 16'h0000, 1, 0, 5'b00000, FZ, 5'b01010, 0, 1, 2, 0);
    cyc("push3_ldcc",      1, 0, 1, 0, 16'h8000, 0, 0, 5'b00000, FN, FN,       0, 1, 3, 0);
    cyc("push4",           0, 0, 1, 0, 16'h0000, 0, 0, 5'b00000, FN, FN,       0, 1, 4, 0);
    cyc("push_full",       0, 0, 1, 0, 16'h0000, 0, 0, 5'b00000, FN, FN,       0, 1, 4, 1);
    cyc("idle_full",       0, 0, 0, 0, 16'h0000, 0, 0, 5'b00000, FN, FN,       0, 1, 4, 0);
    cyc("push_pop_ldcc",   1, 0, 1, 1, 16'h0001, 0, 0, 5'b00000, FP, FP,       0, 1, 4, 1);
    cyc("pop4",            0, 0, 0, 1, 16'h0000, 0, 0, 5'b00000, FN, FN,       0, 1, 3, 0);
    cyc("pop3_ldcc",       1, 0, 0, 1, 16'h0001, 0, 0, 5'b00000, FZ, 5'b01010, 0, 1, 2, 0);
    cyc("pop2",            0, 0, 0, 1, 16'h0000, 0, 0, 5'b00000, FN, FN,       0, 1, 1, 0);
    cyc("pop1_ldcc",       1, 0, 0, 1, 16'h0000, 0, 0, 5'b00000, FP, FP,       0, 1, 0, 0);
    cyc("pop_empty_ldcc",  1, 0, 0, 1, 16'h8000, 0, 0, 5'b00000, FN, FN,       0, 1, 0, 1);
    cyc("pop_empty",       0, 0, 0, 1, 16'h0000, 0, 0, 5'b00000, FN, FN,       0, 1, 0, 1);
    cyc("idle_empty",      0, 0, 0, 0, 16'h0000, 0, 0, 5'b00000, FN, FN,       0, 1, 0, 0);
    cyc("fill1",           0, 0, 1, 0, 16'h0000, 0, 0, 5'b00000, FN, FN,       0, 1, 1, 0);
    cyc("fill2",           0, 0, 1, 0, 16'h0000, 0, 0, 5'b00000, FN, FN,       0, 1, 2, 0);
    cyc("fill3",           0, 0, 1, 0, 16'h0000, 0, 0, 5'b00000, FN, FN,       0, 1, 3, 0);

    // Reset pulse strictly between edges with depth 3.
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("async_reset/ext0", obs0(), mk(5'b0, 0, 0, 0));
    check("async_reset/ext1", obs1(), mk(5'b0, 0, 0, 0));
    #1 Reset = 1'b1;

    // Push held across an edge during reset must be aborted.
    @(negedge Clk);
    Reset = 1'b0;
    drive(0, 0, 1, 0, 16'h0000, 0, 0, 5'b00000);
    it.name = "push_in_reset";
    it.e0   = mk(5'b0, 0, 0, 0);
    it.e1   = mk(5'b0, 0, 0, 0);
    sb.push_back(it);
    @(posedge Clk);
    #2 Reset = 1'b1;

    cyc("push_after_rst",  0, 0, 1, 0, 16'h0000, 0, 0, 5'b00000, 5'b0, 5'b0, 0, 0, 1, 0);
    cyc("ldcc_after_rst",  1, 0, 0, 0, 16'h8000, 0, 0, 5'b00000, FN, FN,     0, 0, 1, 0);
    cyc("pop_after_rst",   0, 0, 0, 1, 16'h0000, 0, 0, 5'b00000, 5'b0, 5'b0, 0, 0, 0, 0);
    cyc("final_idle",      0, 0, 0, 0, 16'h0000, 0, 0, 5'b00000, 5'b0, 5'b0, 0, 0, 0, 0);

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(negedge Clk);
      wait_cycles++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
